// File: rtl/led_centroid_finder.sv
// led_centroid_finder: accumulates per-LED pixel count and x/y sums over one
// readback frame, divides them serially (restoring, one quotient bit per
// cycle) and streams one (id, x, y, found) record per LED in ascending order.
// Optional feature macro: CENTROID_MIN_PIXELS_EN -- found requires at least
// MIN_PIXELS pixels instead of at least one.
module led_centroid_finder #(
    parameter int NUM_LEDS          = 50,
    parameter int LED_ADDRESS_WIDTH = 10,
    parameter int X_WIDTH           = 9,   // must be >= Y_WIDTH (shared divider shifter)
    parameter int Y_WIDTH           = 8,
    parameter int COUNT_WIDTH       = 16,
    parameter int MIN_PIXELS        = 4
) (
    input  logic                         clk_pixel,
    input  logic                         rst,
    input  logic                         start_in,
    input  logic                         new_frame_in,
    input  logic                         id_valid_in,
    input  logic [LED_ADDRESS_WIDTH-1:0] id_in,
    input  logic [X_WIDTH-1:0]           x_in,
    input  logic [Y_WIDTH-1:0]           y_in,
    output logic [LED_ADDRESS_WIDTH-1:0] led_id_out,
    output logic [X_WIDTH-1:0]           x_out,
    output logic [Y_WIDTH-1:0]           y_out,
    output logic                         found_out,
    output logic                         valid_out,
    input  logic                         ready_in,
    output logic                         busy_out,
    output logic                         done_out,
    output logic [COUNT_WIDTH-1:0]       discard_count_out
);

    localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int SX_W  = X_WIDTH + COUNT_WIDTH;
    localparam int SY_W  = Y_WIDTH + COUNT_WIDTH;
    localparam int BC_W  = $clog2(X_WIDTH + 1);

    localparam logic [IDX_W-1:0]             LAST_IDX = IDX_W'(NUM_LEDS - 1);
    localparam logic [LED_ADDRESS_WIDTH-1:0] NUM_IDS  = LED_ADDRESS_WIDTH'(NUM_LEDS);
`ifdef CENTROID_MIN_PIXELS_EN
    localparam logic [COUNT_WIDTH-1:0]       FOUND_MIN = COUNT_WIDTH'(MIN_PIXELS);
`else
    localparam logic [COUNT_WIDTH-1:0]       FOUND_MIN = COUNT_WIDTH'(1);
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_WAIT_FRAME, S_ACCUM, S_DIVIDE, S_EMIT
    } state_t;

    // Per-LED accumulators; sums are wide enough that they never overflow
    // before the count saturates.
    logic [COUNT_WIDTH-1:0] cnt_mem [NUM_LEDS];
    logic [SX_W-1:0]        sx_mem  [NUM_LEDS];
    logic [SY_W-1:0]        sy_mem  [NUM_LEDS];

    state_t                 state_q;
    logic [IDX_W-1:0]       index_q;
    logic [BC_W-1:0]        bit_cnt_q;
    logic                   phase_y_q;
    logic [COUNT_WIDTH-1:0] div_q;
    logic [COUNT_WIDTH-1:0] rem_q;
    logic [X_WIDTH-1:0]     num_q;     // dividend low bits in, quotient bits out
    logic [X_WIDTH-1:0]     x_q;
    logic [Y_WIDTH-1:0]     y_q;
    logic                   found_q;
    logic                   done_q;
    logic [COUNT_WIDTH-1:0] discard_q;

    logic                   pix_in_range;
    logic                   accum_en;
    logic                   rec_start;
    logic [IDX_W-1:0]       pix_idx;
    logic [IDX_W-1:0]       ld_idx;
    logic [COUNT_WIDTH-1:0] ld_cnt;
    logic [SX_W-1:0]        ld_sx;
    logic [SY_W-1:0]        cur_sy;
    logic [COUNT_WIDTH:0]   rem_shift;
    logic                   q_bit;
    logic [COUNT_WIDTH-1:0] rem_d;
    logic [X_WIDTH-1:0]     num_d;

    // Pixel qualification, next-record operand fetch and one restoring divide step.
    // NOTE: every signal here is assigned on every path, so no latch can be inferred.
    always_comb begin
        pix_in_range = (id_in < NUM_IDS);
        pix_idx      = id_in[IDX_W-1:0];
        // The pixel coinciding with the closing frame strobe is outside the window.
        accum_en     = (state_q == S_ACCUM) && !new_frame_in && id_valid_in && pix_in_range;
        rec_start    = ((state_q == S_ACCUM) && new_frame_in) ||
                       ((state_q == S_EMIT) && ready_in && (index_q != LAST_IDX));
        ld_idx       = (state_q == S_EMIT) ? index_q + IDX_W'(1) : '0;
        ld_cnt       = cnt_mem[ld_idx];
        ld_sx        = sx_mem[ld_idx];
        cur_sy       = sy_mem[index_q];
        rem_shift    = {rem_q, num_q[X_WIDTH-1]};
        q_bit        = (rem_shift >= {1'b0, div_q});
        rem_d        = q_bit ? (rem_shift[COUNT_WIDTH-1:0] - div_q) : rem_shift[COUNT_WIDTH-1:0];
        num_d        = {num_q[X_WIDTH-2:0], q_bit};
    end

    // Accumulator update: clear one LED per CLEAR cycle, else single-cycle read-modify-write.
    // NOTE: the accumulator arrays are deliberately not reset; CLEAR zeroes them
    // before every capture, which keeps them out of the reset tree.
    always_ff @(posedge clk_pixel) begin
        if (state_q == S_CLEAR) begin
            cnt_mem[index_q] <= '0;
            sx_mem[index_q]  <= '0;
            sy_mem[index_q]  <= '0;
        end else if (accum_en && !(&cnt_mem[pix_idx])) begin
            cnt_mem[pix_idx] <= cnt_mem[pix_idx] + COUNT_WIDTH'(1);
            sx_mem[pix_idx]  <= sx_mem[pix_idx] + SX_W'(x_in);
            sy_mem[pix_idx]  <= sy_mem[pix_idx] + SY_W'(y_in);
        end
    end

    // Control FSM, serial divider and registered record outputs.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_pixel or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            index_q   <= '0;
            bit_cnt_q <= '0;
            phase_y_q <= 1'b0;
            div_q     <= '0;
            rem_q     <= '0;
            num_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            found_q   <= 1'b0;
            done_q    <= 1'b0;
            discard_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_in) begin
                        state_q <= S_CLEAR;
                        index_q <= '0;
                    end
                end
                S_CLEAR: begin
                    discard_q <= '0;
                    if (index_q == LAST_IDX) begin
                        index_q <= '0;
                        state_q <= S_WAIT_FRAME;
                    end else begin
                        index_q <= index_q + IDX_W'(1);
                    end
                end
                S_WAIT_FRAME: begin
                    if (new_frame_in) state_q <= S_ACCUM;
                end
                S_ACCUM: begin
                    if (!new_frame_in && id_valid_in && !pix_in_range && !(&discard_q))
                        discard_q <= discard_q + COUNT_WIDTH'(1);
                end
                S_DIVIDE: begin
                    rem_q     <= rem_d;
                    num_q     <= num_d;
                    bit_cnt_q <= bit_cnt_q + BC_W'(1);
                    if (!phase_y_q && (bit_cnt_q == BC_W'(X_WIDTH - 1))) begin
                        // x quotient complete; load y, left-aligned in the shifter.
                        x_q       <= num_d;
                        phase_y_q <= 1'b1;
                        bit_cnt_q <= '0;
                        rem_q     <= cur_sy[SY_W-1:Y_WIDTH];
                        num_q     <= X_WIDTH'(cur_sy[Y_WIDTH-1:0]) << (X_WIDTH - Y_WIDTH);
                    end else if (phase_y_q && (bit_cnt_q == BC_W'(Y_WIDTH - 1))) begin
                        y_q     <= num_d[Y_WIDTH-1:0];
                        state_q <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (ready_in && (index_q == LAST_IDX)) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // Start a record: the upper sum bits seed the remainder (always < count,
            // since the average fits in the coordinate width); empty LEDs skip division.
            if (rec_start) begin
                index_q   <= ld_idx;
                x_q       <= '0;
                y_q       <= '0;
                found_q   <= (ld_cnt >= FOUND_MIN);
                div_q     <= ld_cnt;
                rem_q     <= ld_sx[SX_W-1:X_WIDTH];
                num_q     <= ld_sx[X_WIDTH-1:0];
                bit_cnt_q <= '0;
                phase_y_q <= 1'b0;
                state_q   <= (ld_cnt == '0) ? S_EMIT : S_DIVIDE;
            end
        end
    end

    assign led_id_out        = LED_ADDRESS_WIDTH'(index_q);
    assign x_out             = x_q;
    assign y_out             = y_q;
    assign found_out         = found_q;
    assign valid_out         = (state_q == S_EMIT);
    assign busy_out          = (state_q != S_IDLE);
    assign done_out          = done_q;
    assign discard_count_out = discard_q;

endmodule

// File: tb/tb_led_centroid_finder.sv
// Scoreboard bench for led_centroid_finder: stimulus pushes hand-computed
// records, a negedge monitor pops and compares on each handshake.
`timescale 1ns/1ps
module tb_led_centroid_finder;

    localparam int NUM_LEDS = 50;
    localparam int LAW      = 10;
    localparam int XW       = 9;
    localparam int YW       = 8;
    localparam int CW       = 16;

    logic            clk_pixel = 1'b0;
    logic            rst;
    logic            start_in, new_frame_in, id_valid_in, ready_in;
    logic [LAW-1:0]  id_in;
    logic [XW-1:0]   x_in;
    logic [YW-1:0]   y_in;
    logic [LAW-1:0]  led_id_out;
    logic [XW-1:0]   x_out;
    logic [YW-1:0]   y_out;
    logic            found_out, valid_out, busy_out, done_out;
    logic [CW-1:0]   discard_count_out;

    typedef struct packed {
        logic [LAW-1:0] id;
        logic [XW-1:0]  x;
        logic [YW-1:0]  y;
        logic           found;
    } rec_t;

    rec_t sb_q[$];
    rec_t exp_tab [NUM_LEDS];
    rec_t mon_exp;
    rec_t mon_act;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   rec_seen  = 0;
    int   done_seen = 0;
    bit   prev_done = 1'b0;

`ifdef CENTROID_MIN_PIXELS_EN
    localparam logic FOUND_3PIX = 1'b0;
`else
    localparam logic FOUND_3PIX = 1'b1;
`endif

    led_centroid_finder dut (
        .clk_pixel         (clk_pixel),
        .rst               (rst),
        .start_in          (start_in),
        .new_frame_in      (new_frame_in),
        .id_valid_in       (id_valid_in),
        .id_in             (id_in),
        .x_in              (x_in),
        .y_in              (y_in),
        .led_id_out        (led_id_out),
        .x_out             (x_out),
        .y_out             (y_out),
        .found_out         (found_out),
        .valid_out         (valid_out),
        .ready_in          (ready_in),
        .busy_out          (busy_out),
        .done_out          (done_out),
        .discard_count_out (discard_count_out)
    );

    always #5 clk_pixel = ~clk_pixel;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Monitor: compares every accepted record against the scoreboard head.
    always @(negedge clk_pixel) begin
        if (!rst) begin
            if (prev_done) check("busy_after_done", 32'(busy_out), 32'd0);
            prev_done = done_out;
            if (done_out) begin
                done_seen++;
                check("busy_at_done", 32'(busy_out), 32'd0);
            end
            if (valid_out && ready_in) begin
                rec_seen++;
                mon_act = {led_id_out, x_out, y_out, found_out};
                total_cnt++;
                if (sb_q.size() == 0) begin
                    $display("FAIL unexpected_record: got id=%0d with empty scoreboard", led_id_out);
                end else begin
                    mon_exp = sb_q.pop_front();
                    if (mon_act === mon_exp) pass_cnt++;
                    else $display("FAIL record: got id=%0d x=%0d y=%0d f=%0d, expected id=%0d x=%0d y=%0d f=%0d",
                                  mon_act.id, mon_act.x, mon_act.y, mon_act.found,
                                  mon_exp.id, mon_exp.x, mon_exp.y, mon_exp.found);
                end
            end
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic pixel(input int id, input int x, input int y);
        id_valid_in = 1'b1;
        id_in       = LAW'(id);
        x_in        = XW'(x);
        y_in        = YW'(y);
        tick();
    endtask

    task automatic idle();
        id_valid_in = 1'b0;
    endtask

    task automatic frame_pulse();
        new_frame_in = 1'b1;
        tick();
        new_frame_in = 1'b0;
    endtask

    task automatic start_and_clear();
        rec_seen    = 0;
        done_seen   = 0;
        start_in    = 1'b1;
        tick();
        start_in    = 1'b0;
        repeat (60) tick();
    endtask

    task automatic clear_tab();
        for (int i = 0; i < NUM_LEDS; i++) begin
            exp_tab[i].id    = LAW'(i);
            exp_tab[i].x     = '0;
            exp_tab[i].y     = '0;
            exp_tab[i].found = 1'b0;
        end
    endtask

    task automatic set_tab(input int id, input int x, input int y, input logic f);
        exp_tab[id].x     = XW'(x);
        exp_tab[id].y     = YW'(y);
        exp_tab[id].found = f;
    endtask

    task automatic push_tab();
        for (int i = 0; i < NUM_LEDS; i++) sb_q.push_back(exp_tab[i]);
    endtask

    task automatic wait_valid(input string name, input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_pixel);
            if (valid_out) begin
                got = 1'b1;
                break;
            end
        end
        check({name, "_valid_seen"}, 32'(got), 32'd1);
    endtask

    task automatic finish_capture(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_pixel);
            if (done_out) begin
                got = 1'b1;
                break;
            end
        end
        check({name, "_done_seen"}, 32'(got), 32'd1);
        repeat (3) @(negedge clk_pixel);
        check({name, "_done_pulses"}, 32'(done_seen), 32'd1);
        check({name, "_record_count"}, 32'(rec_seen), 32'(NUM_LEDS));
        check({name, "_scoreboard_left"}, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        tick();
    endtask

    initial begin
        rst = 1'b1; start_in = 1'b0; new_frame_in = 1'b0; id_valid_in = 1'b0;
        id_in = '0; x_in = '0; y_in = '0; ready_in = 1'b1;
        repeat (3) @(posedge clk_pixel);
        #1;
        check("rst_valid",   32'(valid_out), 32'd0);
        check("rst_busy",    32'(busy_out), 32'd0);
        check("rst_done",    32'(done_out), 32'd0);
        check("rst_found",   32'(found_out), 32'd0);
        check("rst_xy",      32'({x_out, y_out}), 32'd0);
        check("rst_id",      32'(led_id_out), 32'd0);
        check("rst_discard", 32'(discard_count_out), 32'd0);
        rst = 1'b0;
        tick();

        // Single LED, consecutive pixels of the same ID.
        start_and_clear();
        frame_pulse();
        pixel(3, 10, 20); pixel(3, 12, 22); pixel(3, 14, 27);
        idle();
        clear_tab(); set_tab(3, 12, 23, 1'b1); push_tab();
        frame_pulse();
        check("single_busy_during", 32'(busy_out), 32'd1);
        finish_capture("single");
        check("single_discard", 32'(discard_count_out), 32'd0);

        // Wide sums and floor rounding.
        start_and_clear();
        frame_pulse();
        for (int i = 0; i < 1000; i++) pixel(0, 319, 179);
        for (int i = 0; i < 1000; i++) pixel(0, 0, 0);
        idle();
        clear_tab(); set_tab(0, 159, 89, 1'b1); push_tab();
        frame_pulse();
        finish_capture("floor");

        // Discards, window edges, ignored start, highest valid ID.
        start_and_clear();
        pixel(1, 50, 50); pixel(1, 50, 50); pixel(1, 50, 50);
        idle();
        frame_pulse();
        for (int i = 0; i < 5; i++) pixel(60, 1, 1);
        start_in = 1'b1;
        pixel(1, 7, 9);
        start_in = 1'b0;
        pixel(49, 319, 0);
        idle();
        clear_tab(); set_tab(1, 7, 9, 1'b1); set_tab(49, 319, 0, 1'b1); push_tab();
        new_frame_in = 1'b1;
        pixel(1, 100, 100);
        new_frame_in = 1'b0;
        idle();
        finish_capture("window");
        repeat (5) tick();
        check("discard_hold", 32'(discard_count_out), 32'd5);

        // Backpressure on record 0, plus the first out-of-range ID.
        ready_in = 1'b0;
        start_and_clear();
        check("discard_cleared", 32'(discard_count_out), 32'd0);
        frame_pulse();
        pixel(0, 5, 6); pixel(50, 1, 1);
        idle();
        clear_tab(); set_tab(0, 5, 6, 1'b1); push_tab();
        frame_pulse();
        wait_valid("stall", 200);
        for (int i = 0; i < 10; i++) begin
            check("stall_record", 32'({led_id_out, x_out, y_out, found_out}),
                  32'({10'd0, 9'd5, 8'd6, 1'b1}));
            check("stall_valid", 32'(valid_out), 32'd1);
            @(negedge clk_pixel);
        end
        @(posedge clk_pixel);
        #1;
        ready_in = 1'b1;
        finish_capture("stall");
        check("discard_boundary", 32'(discard_count_out), 32'd1);

        // Reset during ACCUM.
        start_and_clear();
        frame_pulse();
        pixel(4, 30, 30); pixel(4, 30, 30); pixel(4, 30, 30);
        rst = 1'b1;
        #1;
        check("rst_accum_valid", 32'(valid_out), 32'd0);
        check("rst_accum_busy",  32'(busy_out), 32'd0);
        idle();
        tick();
        rst = 1'b0;
        tick();

        // Reset during EMIT.
        start_and_clear();
        frame_pulse();
        pixel(4, 30, 30);
        idle();
        ready_in = 1'b0;
        frame_pulse();
        wait_valid("rst_emit", 200);
        #1;
        rst = 1'b1;
        #1;
        check("rst_emit_valid", 32'(valid_out), 32'd0);
        check("rst_emit_busy",  32'(busy_out), 32'd0);
        tick();
        rst = 1'b0;
        ready_in = 1'b1;
        tick();

        // Fresh capture after the aborted ones: LED 4 must read empty.
        start_and_clear();
        frame_pulse();
        pixel(7, 1, 2);
        idle();
        clear_tab(); set_tab(7, 1, 2, 1'b1); push_tab();
        frame_pulse();
        finish_capture("fresh");

        // Minimum-pixel threshold: 3 pixels on LED 2, 4 pixels on LED 5.
        start_and_clear();
        frame_pulse();
        pixel(2, 10, 10); pixel(2, 11, 11); pixel(2, 12, 13);
        pixel(5, 10, 10); pixel(5, 11, 11); pixel(5, 12, 13); pixel(5, 13, 14);
        idle();
        clear_tab(); set_tab(2, 11, 11, FOUND_3PIX); set_tab(5, 11, 12, 1'b1); push_tab();
        frame_pulse();
        finish_capture("minpix");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
